mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller of the in-order pipeline: accepts one `Uop::execute_t` per handshake from execute, sequences the single data-bus access it requires (alignment check, byte-lane steering, nack retry, load extraction/extension), and hands a `Uop::memory_t` to writeback. Non-memory uops and uops already carrying an exception pass through without a bus access. At most one bus transaction is outstanding.

## Interface
- Parameter `MAX_RETRY`, default 3: re-issues after a nack before reporting `memNack`; range 1–15.
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `flush` in 1: drop the held uop (pipeline redirect).
- `inValid` in 1 / `inReady` out 1 / `in` in `execute_t`: upstream handshake.
- `outValid` out 1 / `outReady` in 1 / `out` out `memory_t`: downstream handshake.
- `dbusReqValid` out 1 / `dbusReqReady` in 1: request handshake.
- `dbusAddr` out 30: word address (`waddr_t`).
- `dbusWe` out 1: store.
- `dbusBe` out 4: byte enables.
- `dbusWdata` out 32: lane-replicated store data.
- `dbusRspValid` in 1 / `dbusRspNack` in 1 / `dbusRdata` in 32: response, one cycle, no backpressure.

## Operation
- States: IDLE, REQ, WAIT, DRAIN. The output register (`outValid`, `out`) is separate from the FSM.
- `inReady` = state IDLE && (!outValid || outReady) && !rst && !flush.
- Accepting in IDLE:
  - If `in.exValid`, or neither `isLd` nor `isSt`: load the output register directly. `out.ex/exValid/rd/rdVal/flagsValid/flags` copy from `in`; `memNack` = 0.
  - Otherwise check alignment on address `in.rdVal`. H needs bit0 = 0. W needs bits[1:0] = 0. Size encoding 3 is treated as misaligned. On a misaligned access, output directly with `exValid` = 1 and `ex` = EX_MEM_ALIGN; no bus access.
  - If aligned, latch the uop and go to REQ.
  - If `isLd` and `isSt` are both set, the uop is treated as a load.
- REQ: `dbusReqValid` = 1. Address = `rdVal[31:2]`. Byte enables:
  - B: `1 << addr[1:0]`.
  - H: `addr[1] ? 4'b1100 : 4'b0011`.
  - W: `4'b1111`.
- Store data:
  - B: the byte replicated to all 4 lanes.
  - H: the halfword replicated to both halves.
  - W: unchanged.
- On request handshake, go to WAIT.
- WAIT, on `dbusRspValid`:
  - Nack with retry count < MAX_RETRY: increment the count, go to REQ.
  - Otherwise: load the output register, clear the count, go to IDLE. For a load, `rdVal` = the extracted lane (`dbusRdata >> 8*offset`, masked to size, sign- or zero-extended per `signExtend`). `memNack` = the nack bit, `exValid` = 0.
- A store's `rdVal` passes through unchanged.
- The output register holds while `outValid && !outReady`.
- `flush` (synchronous):
  - Clears `outValid` and the retry count.
  - IDLE/REQ: go to IDLE. The REQ request is withdrawn even if `dbusReqReady` is high that cycle; the handshake does not count.
  - WAIT: go to DRAIN. DRAIN discards the next `dbusRspValid`, then goes to IDLE. `inReady` = 0 in DRAIN.
- A response arriving outside WAIT/DRAIN is ignored.

## Timing
- Reset values: state IDLE, `outValid` 0, `out` all zero, `dbusReqValid` 0, `dbusAddr`/`dbusBe`/`dbusWdata`/`dbusWe` 0, retry count 0. `inReady` is 0 during reset and 1 in the first cycle after it.
- Pass-through and misaligned: accepted in cycle N, `outValid` in N+1.
- Memory access: accepted in N, `dbusReqValid` in N+1. With immediate ready, the response is earliest in N+2 and `outValid` in N+3.
- Each nack adds at least 2 cycles (WAIT→REQ→WAIT).
- Back-to-back: a new uop is accepted in the same cycle the previous output handshakes.
- `rst` wins over `flush`. `flush` wins over acceptance in the same cycle.

## Configuration
- `MEM_STAGE_NACK_RETRY_EN` defined: nack retry as described, up to MAX_RETRY re-issues.
- Undefined: the first nacked response completes immediately with `memNack` = 1; the retry counter is not built and MAX_RETRY is ignored.

## Test plan
- Load byte, sign-extended, `rdVal` = 0x1003, `dbusRdata` = 0x80FF_0000 → `dbusAddr` = 0x400, `dbusBe` = 4'b1000, `out.rdVal` = 0xFFFF_FF80, `outValid` 3 cycles after acceptance.
- Store halfword, `rdVal` = 0x22, `rs2Val` = 0x1234_ABCD → `dbusBe` = 4'b1100, `dbusWdata` = 0xABCD_ABCD, `dbusWe` = 1.
- Load word, `rdVal` = 0x6 → no `dbusReqValid`; `out.exValid` = 1, `out.ex` = EX_MEM_ALIGN, next cycle.
- With retry enabled and MAX_RETRY = 3, four consecutive nacks → exactly 4 requests issued, then `out.memNack` = 1. Repeat with the macro undefined → 1 request, `memNack` = 1.
- `flush` in WAIT, response 2 cycles later → response discarded, no `outValid`, `inReady` = 0 until the cycle after the response.
- `outReady` held 0 for 5 cycles with a pass-through uop → `out` stable, `inReady` = 0. On release, a new uop is accepted in the same cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Uop bundle types and the memory-stage handshake/bus interface.
// slave = controller side, master = pipeline/bus environment side.
package Uop;
    typedef logic [29:0] waddr_t;
    typedef logic [3:0] ex_t;

    localparam ex_t EX_NONE      = 4'd0;
    localparam ex_t EX_MEM_ALIGN = 4'd6;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_t;

    typedef struct packed {
        ex_t         ex;
        logic        exValid;
        logic [4:0]  rd;
        logic [31:0] rdVal;
        logic        flagsValid;
        logic [3:0]  flags;
        logic        isLd;
        logic        isSt;
        size_t       size;
        logic        signExtend;
        logic [31:0] rs2Val;
    } execute_t;

    typedef struct packed {
        ex_t         ex;
        logic        exValid;
        logic [4:0]  rd;
        logic [31:0] rdVal;
        logic        flagsValid;
        logic [3:0]  flags;
        logic        memNack;
    } memory_t;
endpackage

interface mem_stage_ctrl_if;
    import Uop::*;

    logic        flush;
    logic        inValid;
    logic        inReady;
    execute_t    in;
    logic        outValid;
    logic        outReady;
    memory_t     out;
    logic        dbusReqValid;
    logic        dbusReqReady;
    waddr_t      dbusAddr;
    logic        dbusWe;
    logic [3:0]  dbusBe;
    logic [31:0] dbusWdata;
    logic        dbusRspValid;
    logic        dbusRspNack;
    logic [31:0] dbusRdata;

    modport slave (
        input  flush, inValid, in, outReady,
        input  dbusReqReady, dbusRspValid, dbusRspNack, dbusRdata,
        output inReady, outValid, out,
        output dbusReqValid, dbusAddr, dbusWe, dbusBe, dbusWdata
    );

    modport master (
        output flush, inValid, in, outReady,
        output dbusReqReady, dbusRspValid, dbusRspNack, dbusRdata,
        input  inReady, outValid, out,
        input  dbusReqValid, dbusAddr, dbusWe, dbusBe, dbusWdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: one data-bus access per uop, execute -> writeback.
// Define MEM_STAGE_NACK_RETRY_EN to re-issue nacked accesses up to MAX_RETRY times.
module mem_stage_ctrl
    import Uop::*;
#(
    parameter int MAX_RETRY = 3
) (
    input logic clk,
    input logic rst,
    mem_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    execute_t    held;
    memory_t     out_q;
    memory_t     out_direct;
    memory_t     out_mem;
    logic        out_valid;
    logic        accept;
    logic        is_mem;
    logic        misalign;
    logic        take_mem;
    logic        direct;
    logic        req_fire;
    logic        rsp_done;
    logic        retry_inc;
    logic        can_retry;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] load_val;
    waddr_t      req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_we;

    assign is_mem = (bus.in.isLd || bus.in.isSt) && !bus.in.exValid;

    always_comb begin
        misalign = 1'b1;
        unique case (bus.in.size)
            SZ_B: misalign = 1'b0;
            SZ_H: misalign = bus.in.rdVal[0];
            SZ_W: misalign = |bus.in.rdVal[1:0];
            SZ_X: misalign = 1'b1;
            default: misalign = 1'b1;
        endcase
    end

    assign bus.inReady = (state == IDLE) && (!out_valid || bus.outReady)
                         && !rst && !bus.flush;
    assign accept   = bus.inValid && bus.inReady;
    assign take_mem = accept && is_mem && !misalign;
    assign direct   = accept && !take_mem;

    assign bus.dbusReqValid = (state == REQ) && !bus.flush && !rst;
    assign req_fire = bus.dbusReqValid && bus.dbusReqReady;

`ifdef MEM_STAGE_NACK_RETRY_EN
    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);
    logic [3:0] retry_cnt;

    assign can_retry = bus.dbusRspNack && (retry_cnt < MAX_R);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 4'd1;
        end else if (rsp_done) begin
            retry_cnt <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = retry_inc ^ (MAX_RETRY > 0);
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rsp_done  = 1'b0;
        retry_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (take_mem) state_nxt = REQ;
            end
            REQ: begin
                if (bus.flush) state_nxt = IDLE;
                else if (req_fire) state_nxt = WAIT;
            end
            WAIT: begin
                // a response landing with the flush is the one to discard
                if (bus.flush) begin
                    state_nxt = bus.dbusRspValid ? IDLE : DRAIN;
                end else if (bus.dbusRspValid) begin
                    if (can_retry) begin
                        retry_inc = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        rsp_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.dbusRspValid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
        end else if (take_mem) begin
            held <= bus.in;
        end
    end

    always_comb begin
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        req_we    = 1'b0;
        if (state == REQ) begin
            req_addr = held.rdVal[31:2];
            req_we   = held.isSt && !held.isLd;
            unique case (held.size)
                SZ_B: begin
                    req_be    = 4'b0001 << held.rdVal[1:0];
                    req_wdata = {4{held.rs2Val[7:0]}};
                end
                SZ_H: begin
                    req_be    = held.rdVal[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{held.rs2Val[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = held.rs2Val;
                end
            endcase
        end
    end

    assign bus.dbusAddr  = req_addr;
    assign bus.dbusBe    = req_be;
    assign bus.dbusWdata = req_wdata;
    assign bus.dbusWe    = req_we;

    assign off     = held.rdVal[1:0];
    assign shifted = bus.dbusRdata >> {off, 3'b000};

    always_comb begin
        load_val = shifted;
        unique case (held.size)
            SZ_B: load_val = held.signExtend
                           ? {{24{shifted[7]}}, shifted[7:0]}
                           : {24'b0, shifted[7:0]};
            SZ_H: load_val = held.signExtend
                           ? {{16{shifted[15]}}, shifted[15:0]}
                           : {16'b0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        out_direct            = '0;
        out_direct.ex         = bus.in.ex;
        out_direct.exValid    = bus.in.exValid;
        out_direct.rd         = bus.in.rd;
        out_direct.rdVal      = bus.in.rdVal;
        out_direct.flagsValid = bus.in.flagsValid;
        out_direct.flags      = bus.in.flags;
        out_direct.memNack    = 1'b0;
        // a memory uop only reaches the direct path when misaligned
        if (is_mem) begin
            out_direct.exValid = 1'b1;
            out_direct.ex      = EX_MEM_ALIGN;
        end
    end

    always_comb begin
        out_mem            = '0;
        out_mem.ex         = held.ex;
        out_mem.exValid    = held.exValid;
        out_mem.rd         = held.rd;
        out_mem.rdVal      = held.isLd ? load_val : held.rdVal;
        out_mem.flagsValid = held.flagsValid;
        out_mem.flags      = held.flags;
        out_mem.memNack    = bus.dbusRspNack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (direct) begin
            out_valid <= 1'b1;
            out_q     <= out_direct;
        end else if (rsp_done) begin
            out_valid <= 1'b1;
            out_q     <= out_mem;
        end else if (out_valid && bus.outReady) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.outValid = out_valid;
    assign bus.out      = out_q;
endmodule
